// File: rtl/fsk_mod_tx.sv
// Framed FSK transmitter: bytes in on valid/ready, UART-style frames out as
// mark/space square-wave tones in fixed windows aligned to reset release.
module fsk_mod_tx #(
  parameter int BIT_CLKS   = 32,
  parameter int MARK_HALF  = 2,
  parameter int SPACE_HALF = 1,
  parameter int DATA_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              fsk_out,
  output logic              busy,
  output logic              bit_start
);

  localparam int CNT_W = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
  localparam int PH_W  = (MARK_HALF > 1) ? $clog2(MARK_HALF) : 1;
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(BIT_CLKS - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(DATA_W - 1);
  localparam logic [PH_W-1:0]  MARK_LAST  = PH_W'(MARK_HALF - 1);
  localparam logic [PH_W-1:0]  SPACE_LAST = PH_W'(SPACE_HALF - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [IDX_W-1:0]  bit_idx;
  logic [PH_W-1:0]   phase;
  logic [PH_W-1:0]   half_last;
  logic              hold_valid;
  logic [DATA_W-1:0] hold_data;
  logic [DATA_W-1:0] shifter;
  logic              win_end;
  logic              accept;
  logic              load;
  logic              send_space;

  assign win_end  = (bit_cnt == CNT_LAST);
  assign accept   = tx_valid && !hold_valid;
  assign load     = win_end && hold_valid && ((state == IDLE) || (state == STOP));
  assign tx_ready = !hold_valid;
  assign busy     = (state != IDLE) || hold_valid;

  // Tone selection follows the bit currently occupying the window.
  assign send_space = (state == START) || ((state == DATA) && !shifter[bit_idx]);
  assign half_last  = send_space ? SPACE_LAST : MARK_LAST;

  // Free-running bit timer; never stalls so windows stay locked to the demod.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt   <= '0;
      bit_start <= 1'b0;
    end else begin
      bit_cnt   <= win_end ? '0 : bit_cnt + 1'b1;
      bit_start <= win_end;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid <= 1'b0;
    end else if (accept) begin
      hold_valid <= 1'b1;
    end else if (load) begin
      hold_valid <= 1'b0;
    end
  end

  // Payload registers carry no reset; hold_valid and state qualify them.
  always_ff @(posedge clk) begin
    if (accept) hold_data <= tx_data;
    if (load)   shifter   <= hold_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bit_idx <= '0;
    end else if (win_end) begin
      case (state)
        IDLE:  if (hold_valid) state <= START;
        START: begin
          state   <= DATA;
          bit_idx <= '0;
        end
        DATA: begin
          if (bit_idx == IDX_LAST) state <= STOP;
          else                     bit_idx <= bit_idx + 1'b1;
        end
        STOP:  state <= hold_valid ? START : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Each window starts low with phase cleared so edge positions are fixed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsk_out <= 1'b0;
      phase   <= '0;
    end else if (win_end) begin
      fsk_out <= 1'b0;
      phase   <= '0;
    end else if (phase == half_last) begin
      fsk_out <= ~fsk_out;
      phase   <= '0;
    end else begin
      phase <= phase + 1'b1;
    end
  end

endmodule

// File: tb/tb_fsk_mod_tx.sv
// Directed bench for fsk_mod_tx: tone shape, framing, handshake timing, reset
// and a behavioural edge-counting demodulator loopback.
module tb_fsk_mod_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       fsk_out;
  logic       busy;
  logic       bit_start;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic exp_bits [0:127];

  fsk_mod_tx dut (
    .clk       (clk),
    .rst       (rst),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .fsk_out   (fsk_out),
    .busy      (busy),
    .bit_start (bit_start)
  );

  always #5 clk = ~clk;

  // Mark: period 4, high on window clks 2,3,6,7,...; space: high on odd clks.
  function automatic logic exp_tone(input logic b, input int t);
    return b ? ((t % 4) >= 2) : ((t % 2) == 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tx_valid = 1'b0;
    tx_data = 8'h00;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic clear_exp();
    for (int i = 0; i < 128; i++) exp_bits[i] = 1'b1;
  endtask

  task automatic add_frame(input int w, input logic [7:0] d);
    exp_bits[w] = 1'b0;
    for (int i = 0; i < 8; i++) exp_bits[w + 1 + i] = d[i];
    exp_bits[w + 9] = 1'b1;
  endtask

  task automatic test_reset();
    int   edges;
    logic prev;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (fsk_out !== 1'b0)   begin errors++; $display("FAIL rst_fsk got %b want 0", fsk_out); end
    checks++; if (tx_ready !== 1'b1)  begin errors++; $display("FAIL rst_ready got %b want 1", tx_ready); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (bit_start !== 1'b0) begin errors++; $display("FAIL rst_bit_start got %b want 0", bit_start); end
    do_reset();
    clear_exp();
    edges = 0;
    prev = 1'b0;
    while (cyc < 128) begin
      checks++;
      if (fsk_out !== exp_tone(1'b1, cyc % 32)) begin
        errors++; $display("FAIL idle_tone cyc=%0d got %b want %b", cyc, fsk_out, exp_tone(1'b1, cyc % 32));
      end
      checks++;
      if (bit_start !== ((cyc % 32 == 0) && (cyc != 0))) begin
        errors++; $display("FAIL idle_bit_start cyc=%0d got %b want %b", cyc, bit_start, (cyc % 32 == 0) && (cyc != 0));
      end
      if ((cyc % 32 != 0) && fsk_out && !prev) edges++;
      prev = fsk_out;
      if (cyc % 32 == 31) begin
        checks++; if (edges != 8) begin errors++; $display("FAIL idle_edges cyc=%0d got %0d want 8", cyc, edges); end
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL idle_ready cyc=%0d got %b want 1", cyc, tx_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy cyc=%0d got %b want 0", cyc, busy); end
        edges = 0;
      end
      tick();
    end
  endtask

  task automatic test_single_a5();
    do_reset();
    clear_exp();
    add_frame(1, 8'hA5);
    while (cyc < 360) begin
      checks++;
      if (fsk_out !== exp_tone(exp_bits[cyc / 32], cyc % 32)) begin
        errors++; $display("FAIL a5_tone cyc=%0d got %b want %b", cyc, fsk_out, exp_tone(exp_bits[cyc / 32], cyc % 32));
      end
      if (cyc == 5) begin
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL a5_ready_pre got %b want 1", tx_ready); end
        tx_valid = 1'b1;
        tx_data = 8'hA5;
      end
      if (cyc == 6) begin
        tx_valid = 1'b0;
        tx_data = 8'h3C;
        checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL a5_ready_post got %b want 0", tx_ready); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL a5_busy_hold got %b want 1", busy); end
      end
      if (cyc == 351) begin
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL a5_busy_stop got %b want 1", busy); end
      end
      if (cyc == 352) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL a5_busy_end got %b want 0", busy); end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    clear_exp();
    add_frame(1, 8'h00);
    add_frame(11, 8'hFF);
    while (cyc < 704) begin
      checks++;
      if (fsk_out !== exp_tone(exp_bits[cyc / 32], cyc % 32)) begin
        errors++; $display("FAIL b2b_tone cyc=%0d got %b want %b", cyc, fsk_out, exp_tone(exp_bits[cyc / 32], cyc % 32));
      end
      case (cyc)
        2: begin tx_valid = 1'b1; tx_data = 8'h00; end
        3: begin
          tx_data = 8'hFF;
          checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready3 got %b want 0", tx_ready); end
        end
        31: begin checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready31 got %b want 0", tx_ready); end end
        32: begin checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready32 got %b want 1", tx_ready); end end
        33: begin
          tx_valid = 1'b0;
          checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready33 got %b want 0", tx_ready); end
        end
        671: begin checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy671 got %b want 1", busy); end end
        672: begin checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy672 got %b want 0", busy); end end
        default: ;
      endcase
      tick();
    end
  endtask

  task automatic test_boundary_accept();
    do_reset();
    clear_exp();
    add_frame(2, 8'h0F);
    while (cyc < 416) begin
      checks++;
      if (fsk_out !== exp_tone(exp_bits[cyc / 32], cyc % 32)) begin
        errors++; $display("FAIL bnd_tone cyc=%0d got %b want %b", cyc, fsk_out, exp_tone(exp_bits[cyc / 32], cyc % 32));
      end
      if (cyc == 31) begin
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL bnd_ready31 got %b want 1", tx_ready); end
        tx_valid = 1'b1;
        tx_data = 8'h0F;
      end
      if (cyc == 32) begin
        tx_valid = 1'b0;
        checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL bnd_ready32 got %b want 0", tx_ready); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL bnd_busy32 got %b want 1", busy); end
      end
      if (cyc == 384) begin
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bnd_busy384 got %b want 0", busy); end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    clear_exp();
    add_frame(1, 8'h00);
    while (cyc < 101) begin
      checks++;
      if (fsk_out !== exp_tone(exp_bits[cyc / 32], cyc % 32)) begin
        errors++; $display("FAIL mid_tone cyc=%0d got %b want %b", cyc, fsk_out, exp_tone(exp_bits[cyc / 32], cyc % 32));
      end
      if (cyc == 1)  begin tx_valid = 1'b1; tx_data = 8'h00; end
      if (cyc == 2)  tx_valid = 1'b0;
      if (cyc == 40) begin tx_valid = 1'b1; tx_data = 8'h55; end
      if (cyc == 41) tx_valid = 1'b0;
      tick();
    end
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL mid_ready_pre got %b want 0", tx_ready); end
    rst = 1'b1;
    #1;
    checks++; if (fsk_out !== 1'b0)   begin errors++; $display("FAIL mid_rst_fsk got %b want 0", fsk_out); end
    checks++; if (tx_ready !== 1'b1)  begin errors++; $display("FAIL mid_rst_ready got %b want 1", tx_ready); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL mid_rst_busy got %b want 0", busy); end
    checks++; if (bit_start !== 1'b0) begin errors++; $display("FAIL mid_rst_bit_start got %b want 0", bit_start); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    clear_exp();
    while (cyc < 128) begin
      checks++;
      if (fsk_out !== exp_tone(1'b1, cyc % 32)) begin
        errors++; $display("FAIL mid_after_tone cyc=%0d got %b want %b", cyc, fsk_out, exp_tone(1'b1, cyc % 32));
      end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL mid_after_busy cyc=%0d got %b want 0", cyc, busy); end
      tick();
    end
  endtask

  task automatic test_loopback();
    logic [7:0] bytes [0:4];
    int   idx;
    int   edges;
    logic prev;
    logic acc;
    logic rec;
    do_reset();
    clear_exp();
    for (int i = 0; i < 5; i++) begin
      bytes[i] = 8'($urandom_range(0, 255));
      add_frame(1 + 10 * i, bytes[i]);
    end
    idx = 0;
    edges = 0;
    prev = 1'b0;
    while (cyc < 53 * 32) begin
      if (cyc == 1) begin tx_valid = 1'b1; tx_data = bytes[0]; end
      if ((cyc % 32 != 0) && fsk_out && !prev) edges++;
      prev = fsk_out;
      if (cyc % 32 == 31) begin
        rec = (edges <= 12);
        checks++;
        if (rec !== exp_bits[cyc / 32]) begin
          errors++; $display("FAIL loop_bit win=%0d got %b want %b edges=%0d", cyc / 32, rec, exp_bits[cyc / 32], edges);
        end
        edges = 0;
      end
      acc = tx_valid && tx_ready;
      tick();
      if (acc) begin
        idx++;
        if (idx >= 5) tx_valid = 1'b0;
        else tx_data = bytes[idx];
      end
    end
    checks++; if (idx != 5) begin errors++; $display("FAIL loop_accepts got %0d want 5", idx); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL loop_busy_end got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_single_a5();
    test_back_to_back();
    test_boundary_accept();
    test_reset_mid_frame();
    test_loopback();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
